// File: rtl/cpu8080_pkg.sv
// Shared types and select encodings for the 8080 machine-cycle sequencer.
// Cycle types, T-state encoding, status bit positions and register-select constants.
package cpu8080_pkg;

  typedef enum logic [2:0] {
    CYC_FETCH  = 3'd0,
    CYC_MEM_RD = 3'd1,
    CYC_MEM_WR = 3'd2,
    CYC_IO_RD  = 3'd3,
    CYC_IO_WR  = 3'd4,
    CYC_INTA   = 3'd5
  } cyc_type_e;

  // IDLE must encode as zero so the debug state reads 0 out of reset
  typedef enum logic [2:0] {
    TS_IDLE = 3'd0,
    TS_T1   = 3'd1,
    TS_T2   = 3'd2,
    TS_TW   = 3'd3,
    TS_T3   = 3'd4,
    TS_T4   = 3'd5
  } tstate_e;

  localparam int ST_INTA  = 0;
  localparam int ST_WO_N  = 1;
  localparam int ST_STACK = 2;
  localparam int ST_HLTA  = 3;
  localparam int ST_OUT   = 4;
  localparam int ST_M1    = 5;
  localparam int ST_INP   = 6;
  localparam int ST_MEMR  = 7;

  localparam logic [2:0] SEL16_BC = 3'd0;
  localparam logic [2:0] SEL16_DE = 3'd1;
  localparam logic [2:0] SEL16_HL = 3'd2;
  localparam logic [2:0] SEL16_SP = 3'd3;
  localparam logic [2:0] SEL16_PC = 3'd4;

  localparam logic [3:0] SEL8_B  = 4'd0;
  localparam logic [3:0] SEL8_C  = 4'd1;
  localparam logic [3:0] SEL8_D  = 4'd2;
  localparam logic [3:0] SEL8_E  = 4'd3;
  localparam logic [3:0] SEL8_H  = 4'd4;
  localparam logic [3:0] SEL8_L  = 4'd5;
  localparam logic [3:0] SEL8_A  = 4'd7;
  localparam logic [3:0] SEL8_SP = 4'd8;
  localparam logic [3:0] SEL8_PC = 4'd9;

  // Unused encodings 6 and 7 fall back to a plain memory read
  function automatic cyc_type_e decode_cyc_type(input logic [2:0] raw);
    return (raw > 3'd5) ? CYC_MEM_RD : cyc_type_e'(raw);
  endfunction

  function automatic logic [7:0] cyc_status(input cyc_type_e t, input logic [2:0] addr_sel);
    logic [7:0] s;
    s           = '0;
    s[ST_INTA]  = (t == CYC_INTA);
    s[ST_WO_N]  = !((t == CYC_MEM_WR) || (t == CYC_IO_WR));
    s[ST_STACK] = (addr_sel == SEL16_SP);
    s[ST_HLTA]  = 1'b0;
    s[ST_OUT]   = (t == CYC_IO_WR);
    s[ST_M1]    = (t == CYC_FETCH) || (t == CYC_INTA);
    s[ST_INP]   = (t == CYC_IO_RD);
    s[ST_MEMR]  = (t == CYC_FETCH) || (t == CYC_MEM_RD);
    return s;
  endfunction

endpackage

// File: rtl/machine_cycle_seq_wait_state_ctr.sv
// Wait-state counter: loads the forced wait count in T1 and counts down to zero
// while the sequencer sits in T2/TW; never wraps below zero.
module wait_state_ctr #(
  parameter int                 WAIT_W   = 4,
  parameter logic [WAIT_W-1:0]  LOAD_VAL = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero
);

  logic [WAIT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/machine_cycle_seq.sv
// 8080 machine-cycle / T-state sequencer: one cycle request at a time, T1..T4 plus wait states.
// Optional bus hold/acknowledge (hold_i/hlda_o) is built when HOLD_EN is defined.
module machine_cycle_seq
  import cpu8080_pkg::*;
#(
  parameter int FIXED_WAIT = 0,
  parameter int WAIT_W     = 4
) (
  input  logic       clk50M_i,
  input  logic       rst_ni,
  input  logic       cyc_req_i,
  input  logic [2:0] cyc_type_i,
  input  logic [2:0] cyc_addr_sel_i,
  input  logic [3:0] cyc_reg_sel_i,
  input  logic       cyc_pc_inc_i,
  input  logic       ready_i,
`ifdef HOLD_EN
  input  logic       hold_i,
  output logic       hlda_o,
`endif
  output logic       cyc_ack_o,
  output logic       cyc_done_o,
  output logic [2:0] reg16_sel_o,
  output logic [3:0] reg8_sel_o,
  output logic       latch_wr_o,
  output logic       latch_rd_o,
  output logic       pc_inc_o,
  output logic       ir_wr_o,
  output logic       reg_write_o,
  output logic       reg_read_o,
  output logic       mem_rd_o,
  output logic       mem_wr_o,
  output logic       sync_o,
  output logic [7:0] status_o,
  output logic       wait_o,
  output logic [2:0] t_state_o
);

  tstate_e    state, state_nxt;
  cyc_type_e  cap_type;
  logic [2:0] cap_addr_sel;
  logic [3:0] cap_reg_sel;
  logic       cap_pc_inc;

  logic is_m1, is_write, is_read, is_final, bus_free, ack;
  logic hold_block, bus_held, cnt_zero;

  assign is_m1    = (cap_type == CYC_FETCH) || (cap_type == CYC_INTA);
  assign is_write = (cap_type == CYC_MEM_WR) || (cap_type == CYC_IO_WR);
  assign is_read  = !is_write;
  assign is_final = (state == TS_T4) || ((state == TS_T3) && !is_m1);
  assign bus_free = (state == TS_IDLE) || is_final;

`ifdef HOLD_EN
  logic hlda_q;

  // Hold is only honoured at a cycle boundary and keeps acks off until hlda has dropped again
  always_ff @(posedge clk50M_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hlda_q <= 1'b0;
    end else if (hlda_q) begin
      hlda_q <= hold_i;
    end else begin
      hlda_q <= hold_i && bus_free;
    end
  end

  assign hold_block = hold_i || hlda_q;
  assign bus_held   = hlda_q;
  assign hlda_o     = hlda_q;
`else
  assign hold_block = 1'b0;
  assign bus_held   = 1'b0;
`endif

  assign ack = cyc_req_i && rst_ni && bus_free && !hold_block;

  always_ff @(posedge clk50M_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= TS_IDLE;
      cap_type     <= CYC_FETCH;
      cap_addr_sel <= '0;
      cap_reg_sel  <= '0;
      cap_pc_inc   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (ack) begin
        cap_type     <= decode_cyc_type(cyc_type_i);
        cap_addr_sel <= cyc_addr_sel_i;
        cap_reg_sel  <= cyc_reg_sel_i;
        cap_pc_inc   <= cyc_pc_inc_i;
      end
    end
  end

  wait_state_ctr #(
    .WAIT_W   (WAIT_W),
    .LOAD_VAL (WAIT_W'(FIXED_WAIT))
  ) u_wait_ctr (
    .clk   (clk50M_i),
    .rst_n (rst_ni),
    .load  (state == TS_T1),
    .dec   ((state == TS_T2) || (state == TS_TW)),
    .zero  (cnt_zero)
  );

  // A request seen in the final clock chains straight into T1 without an IDLE bubble
  always_comb begin
    state_nxt = state;
    case (state)
      TS_IDLE: state_nxt = ack ? TS_T1 : TS_IDLE;
      TS_T1:   state_nxt = TS_T2;
      TS_T2,
      TS_TW:   state_nxt = (ready_i && cnt_zero) ? TS_T3 : TS_TW;
      TS_T3:   state_nxt = is_m1 ? TS_T4 : (ack ? TS_T1 : TS_IDLE);
      TS_T4:   state_nxt = ack ? TS_T1 : TS_IDLE;
      default: state_nxt = TS_IDLE;
    endcase
  end

  always_comb begin
    logic in_cycle, data_phase;
    in_cycle    = (state != TS_IDLE);
    data_phase  = (state == TS_T2) || (state == TS_TW) || (state == TS_T3);

    cyc_ack_o   = ack;
    cyc_done_o  = is_final;
    sync_o      = (state == TS_T1);
    latch_wr_o  = (state == TS_T1);
    reg16_sel_o = (state == TS_T1) ? cap_addr_sel : 3'd0;
    latch_rd_o  = in_cycle && !bus_held;
    reg8_sel_o  = in_cycle ? cap_reg_sel : 4'd0;
    status_o    = in_cycle ? cyc_status(cap_type, cap_addr_sel) : 8'd0;
    pc_inc_o    = (state == TS_T2) && cap_pc_inc;
    mem_rd_o    = is_read && data_phase;
    reg_read_o  = is_write && data_phase;
    mem_wr_o    = is_write && (state == TS_T3);
    ir_wr_o     = is_m1 && (state == TS_T3);
    reg_write_o = ((cap_type == CYC_MEM_RD) || (cap_type == CYC_IO_RD)) && (state == TS_T3);
    wait_o      = (state == TS_TW);
    t_state_o   = state;
  end

endmodule
